hr_monitor: RTL and testbench

- Downstream consumer of alg_core; sits after R-peak detection in the ECG chain.
- Detects each new beat from alg_core's r_peak_sample_num / rr_period outputs.
- Range-checks each RR interval and keeps a sliding average over the last AVG_LEN accepted intervals.
- Converts the average to beats-per-minute with an iterative divider and raises tachycardia/bradycardia flags.

---
 rtl/hr_monitor.sv | 249 ++++++++++++++++++++++++
 tb/tb_hr_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hr_monitor.sv
`default_nettype none
// ============================================================================
// Module      : hr_monitor
// Description : Beat detection, RR range check, sliding RR average and
//               iterative BPM divider with tachy/brady flags. Optional
//               irregular-beat detector enabled by macro HR_MON_IRREG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hr_monitor #(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH  = 22,
    parameter int FS         = 360,
    parameter int AVG_LEN    = 8,
    parameter int RR_MIN     = 72,
    parameter int RR_MAX     = 720,
    parameter int HR_WIDTH   = 9,
    parameter int TACHY_BPM  = 100,
    parameter int BRADY_BPM  = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] rr_period,
    input  logic [CTR_WIDTH-1:0]  r_peak_sample_num,
    output logic [HR_WIDTH-1:0]   heart_rate,
    output logic [DATA_WIDTH-1:0] rr_avg,
    output logic                  hr_valid,
    output logic                  hr_update,
    output logic                  rr_reject,
    output logic                  tachy,
    output logic                  brady,
    output logic                  irregular_beat
);

    localparam int LOG2_AVG = $clog2(AVG_LEN);
    localparam int SUM_W    = DATA_WIDTH + LOG2_AVG;
    localparam int CNT_W    = LOG2_AVG + 1;
    localparam int NUM      = 60 * FS;
    localparam int NUM_W    = $clog2(NUM + 1);
    localparam int STEP_W   = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [CTR_WIDTH-1:0]  r_last_peak;
    logic                  r_pend_vld;
    logic [DATA_WIDTH-1:0] r_pend_rr;

    logic [DATA_WIDTH-1:0] r_buf [AVG_LEN];
    logic [LOG2_AVG-1:0]   r_wptr;
    logic [SUM_W-1:0]      r_sum;
    logic [CNT_W-1:0]      r_count;

    logic [DATA_WIDTH-1:0] r_den;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [NUM_W-1:0]      r_quo;
    logic [STEP_W-1:0]     r_step;

    logic [HR_WIDTH-1:0]   r_heart_rate;
    logic [DATA_WIDTH-1:0] r_rr_avg;
    logic                  r_hr_valid;
    logic                  r_hr_update;
    logic                  r_rr_reject;
    logic                  r_tachy;
    logic                  r_brady;

    logic                  w_beat;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_take_rr;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_full;
    logic [SUM_W-1:0]      w_rr_ext;
    logic [SUM_W-1:0]      w_old_ext;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_ge;
    logic [DATA_WIDTH:0]   w_diff;
    logic [HR_WIDTH-1:0]   w_hr_sat;

    // A beat is any change of the peak index; a pending beat is older and
    // therefore always served before a beat arriving in the same cycle.
    always_comb begin
        w_beat     = ce && (r_peak_sample_num != r_last_peak);
        w_take     = ce && (r_state == S_IDLE) && (r_pend_vld || w_beat);
        w_take_rr  = r_pend_vld ? r_pend_rr : rr_period;
        w_in_range = (w_take_rr >= DATA_WIDTH'(RR_MIN)) &&
                     (w_take_rr <= DATA_WIDTH'(RR_MAX));
        w_accept   = w_take && w_in_range;
        w_reject   = w_take && !w_in_range;
        w_full     = (r_count == CNT_W'(AVG_LEN));
        w_rr_ext   = SUM_W'(w_take_rr);
        w_old_ext  = SUM_W'(r_buf[r_wptr]);
        w_trial    = {r_rem, r_quo[NUM_W-1]};
        w_ge       = (w_trial >= {1'b0, r_den});
        w_diff     = w_trial - {1'b0, r_den};
    end

    generate
        if (NUM_W > HR_WIDTH) begin : g_sat
            assign w_hr_sat = (|r_quo[NUM_W-1:HR_WIDTH]) ? {HR_WIDTH{1'b1}}
                                                         : r_quo[HR_WIDTH-1:0];
        end else begin : g_nosat
            assign w_hr_sat = HR_WIDTH'(r_quo);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCUM;
            S_ACCUM:  w_next = w_full ? S_DIVIDE : S_IDLE;
            S_DIVIDE: if (r_step == STEP_W'(NUM_W - 1)) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Beat capture and one-deep pending slot (newest beat wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_peak <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_rr   <= '0;
        end else if (ce) begin
            if (w_beat) begin
                r_last_peak <= r_peak_sample_num;
            end
            if (w_beat && ((r_state != S_IDLE) || r_pend_vld)) begin
                r_pend_vld <= 1'b1;
                r_pend_rr  <= rr_period;
            end else if (w_take) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Circular window; once full the oldest entry is swapped out in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AVG_LEN; i++) begin
                r_buf[i] <= '0;
            end
            r_wptr  <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_buf[r_wptr] <= w_take_rr;
            r_wptr        <= r_wptr + 1'b1;
            if (w_full) begin
                r_sum <= r_sum + w_rr_ext - w_old_ext;
            end else begin
                r_sum   <= r_sum + w_rr_ext;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Restoring divider: NUM / average, one quotient bit per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_den  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_step <= '0;
        end else if (ce) begin
            if ((r_state == S_ACCUM) && w_full) begin
                r_den  <= r_sum[SUM_W-1:LOG2_AVG];
                r_rem  <= '0;
                r_quo  <= NUM_W'(NUM);
                r_step <= '0;
            end else if (r_state == S_DIVIDE) begin
                r_rem  <= w_ge ? w_diff[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
                r_quo  <= {r_quo[NUM_W-2:0], w_ge};
                r_step <= r_step + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_heart_rate <= '0;
            r_rr_avg     <= '0;
            r_hr_valid   <= 1'b0;
            r_hr_update  <= 1'b0;
            r_rr_reject  <= 1'b0;
            r_tachy      <= 1'b0;
            r_brady      <= 1'b0;
        end else if (ce) begin
            r_hr_update <= (r_state == S_DONE);
            r_rr_reject <= w_reject;
            if (r_state == S_DONE) begin
                r_heart_rate <= w_hr_sat;
                r_rr_avg     <= r_den;
                r_hr_valid   <= 1'b1;
                r_tachy      <= (w_hr_sat > HR_WIDTH'(TACHY_BPM));
                r_brady      <= (w_hr_sat < HR_WIDTH'(BRADY_BPM));
            end
        end
    end

`ifdef HR_MON_IRREG_EN
    logic [DATA_WIDTH-1:0] w_dev;
    logic                  r_irreg;

    // Deviation is measured against the average published before this beat.
    always_comb begin
        w_dev = (w_take_rr >= r_rr_avg) ? (w_take_rr - r_rr_avg)
                                        : (r_rr_avg - w_take_rr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irreg <= 1'b0;
        end else if (ce) begin
            r_irreg <= w_accept && r_hr_valid && (w_dev > (r_rr_avg >> 3));
        end
    end

    assign irregular_beat = r_irreg;
`else
    assign irregular_beat = 1'b0;
`endif

    assign heart_rate = r_heart_rate;
    assign rr_avg     = r_rr_avg;
    assign hr_valid   = r_hr_valid;
    assign hr_update  = r_hr_update;
    assign rr_reject  = r_rr_reject;
    assign tachy      = r_tachy;
    assign brady      = r_brady;

endmodule
`default_nettype wire

// File: tb/tb_hr_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_hr_monitor
// Description : Scoreboard bench for hr_monitor with directed beat vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hr_monitor;

`ifdef HR_MON_IRREG_EN
    localparam bit IR = 1'b1;
`else
    localparam bit IR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [10:0] rr_period;
    logic [21:0] r_peak_sample_num;
    logic [8:0]  heart_rate;
    logic [10:0] rr_avg;
    logic        hr_valid;
    logic        hr_update;
    logic        rr_reject;
    logic        tachy;
    logic        brady;
    logic        irregular_beat;

    hr_monitor dut (
        .clk               (clk),
        .rst               (rst),
        .ce                (ce),
        .rr_period         (rr_period),
        .r_peak_sample_num (r_peak_sample_num),
        .heart_rate        (heart_rate),
        .rr_avg            (rr_avg),
        .hr_valid          (hr_valid),
        .hr_update         (hr_update),
        .rr_reject         (rr_reject),
        .tachy             (tachy),
        .brady             (brady),
        .irregular_beat    (irregular_beat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int hr;
        int avg;
        bit t;
        bit b;
    } upd_t;

    upd_t q_upd[$];
    int   q_rej[$];
    int   q_irr[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   pk     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (hr_update === 1'b1) begin
            if (q_upd.size() == 0) begin
                chk("hr_update expected", q_upd.size(), 1);
            end else begin
                upd_t e;
                e = q_upd.pop_front();
                chk("hr_update cycle", cyc, e.cyc);
                chk("heart_rate", int'(heart_rate), e.hr);
                chk("rr_avg", int'(rr_avg), e.avg);
                chk("hr_valid", int'(hr_valid), 1);
                chk("tachy", int'(tachy), int'(e.t));
                chk("brady", int'(brady), int'(e.b));
            end
        end
        if (rr_reject === 1'b1) begin
            if (q_rej.size() == 0) chk("rr_reject expected", q_rej.size(), 1);
            else chk("rr_reject cycle", cyc, q_rej.pop_front());
        end
        if (irregular_beat === 1'b1) begin
            if (q_irr.size() == 0) chk("irregular_beat expected", q_irr.size(), 1);
            else chk("irregular_beat cycle", cyc, q_irr.pop_front());
        end
    end

    // Issue one beat; lat is the cycle offset of the expected hr_update.
    task automatic beat(input int rr, input bit upd, input int hr, input int avg,
                        input bit t, input bit b, input bit rej, input bit irr,
                        input int lat, input int wt);
        upd_t e;
        @(posedge clk);
        #1;
        pk += 100;
        rr_period         = 11'(rr);
        r_peak_sample_num = 22'(pk);
        if (upd) begin
            e.cyc = cyc + lat; e.hr = hr; e.avg = avg; e.t = t; e.b = b;
            q_upd.push_back(e);
        end
        if (rej) q_rej.push_back(cyc + 1);
        if (irr) q_irr.push_back(cyc + 1);
        repeat (wt) @(posedge clk);
    endtask

    task automatic quiet(input int rr);
        beat(rr, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 18, 20);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " heart_rate"}, int'(heart_rate), 0);
        chk({tag, " rr_avg"}, int'(rr_avg), 0);
        chk({tag, " hr_valid"}, int'(hr_valid), 0);
        chk({tag, " hr_update"}, int'(hr_update), 0);
        chk({tag, " rr_reject"}, int'(rr_reject), 0);
        chk({tag, " tachy"}, int'(tachy), 0);
        chk({tag, " brady"}, int'(brady), 0);
        chk({tag, " irregular_beat"}, int'(irregular_beat), 0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; rr_period = '0; r_peak_sample_num = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_cleared("reset");

        // 4x300 + 3x420: window not yet full, then 8th beat completes it
        for (int i = 0; i < 4; i++) quiet(300);
        for (int i = 0; i < 3; i++) quiet(420);
        chk("hr_valid after 7 beats", int'(hr_valid), 0);
        beat(420, 1, 60, 360, 0, 0, 0, 0, 18, 20);

        // slide to all-360; first beat has ce dropped for 3 cycles mid-divide
        beat(360, 1, 58, 367, 0, 1, 0, 0, 21, 5);
        @(posedge clk); #1 ce = 1'b0;
        repeat (3) @(posedge clk);
        #1 ce = 1'b1;
        repeat (20) @(posedge clk);
        beat(360, 1, 57, 375, 0, 1, 0, 0, 18, 20);
        beat(360, 1, 56, 382, 0, 1, 0, 0, 18, 20);
        beat(360, 1, 55, 390, 0, 1, 0, 0, 18, 20);
        beat(360, 1, 56, 382, 0, 1, 0, 0, 18, 20);
        beat(360, 1, 57, 375, 0, 1, 0, 0, 18, 20);
        beat(360, 1, 58, 367, 0, 1, 0, 0, 18, 20);
        beat(360, 1, 60, 360, 0, 0, 0, 0, 18, 20);

        // 8x200: sliding average tracks down to 200 -> 108 bpm, tachy
        beat(200, 1, 63, 340, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 67, 320, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 72, 300, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 77, 280, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 83, 260, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 90, 240, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 98, 220, 0, 0, 0, IR, 18, 20);
        beat(200, 1, 108, 200, 1, 0, 0, 0, 18, 20);

        // back to all-360
        beat(360, 1, 98, 220, 0, 0, 0, IR, 18, 20);
        beat(360, 1, 90, 240, 0, 0, 0, IR, 18, 20);
        beat(360, 1, 83, 260, 0, 0, 0, IR, 18, 20);
        beat(360, 1, 77, 280, 0, 0, 0, IR, 18, 20);
        beat(360, 1, 72, 300, 0, 0, 0, IR, 18, 20);
        beat(360, 1, 67, 320, 0, 0, 0, IR, 18, 20);
        beat(360, 1, 63, 340, 0, 0, 0, 0, 18, 20);
        beat(360, 1, 60, 360, 0, 0, 0, 0, 18, 20);

        // out-of-range RR on both sides
        beat(50, 0, 0, 0, 0, 0, 1, 0, 18, 20);
        beat(800, 0, 0, 0, 0, 0, 1, 0, 18, 20);
        chk("heart_rate after rejects", int'(heart_rate), 60);
        chk("rr_avg after rejects", int'(rr_avg), 360);

        // irregular-beat probes (results also check the window kept 8x360)
        beat(420, 1, 58, 367, 0, 1, 0, IR, 18, 20);
        beat(400, 1, 58, 372, 0, 1, 0, 0, 18, 20);

        // reset during DIVIDE aborts the pending result
        beat(216, 0, 0, 0, 0, 0, 0, IR, 18, 8);
        @(posedge clk); #1 rst = 1'b1; pk = 0; r_peak_sample_num = '0;
        @(posedge clk); #1 rst = 1'b0;
        check_cleared("mid-divide reset");
        repeat (20) @(posedge clk);
        for (int i = 0; i < 7; i++) quiet(216);
        beat(216, 1, 100, 216, 0, 0, 0, 0, 18, 20);

        // beats while busy: B is overwritten by C, C served after A
        beat(216, 1, 100, 216, 0, 0, 0, 0, 18, 3);
        beat(300, 0, 0, 0, 0, 0, 0, 0, 18, 3);
        beat(240, 1, 98, 219, 0, 0, 0, 0, 28, 40);

        repeat (40) @(posedge clk);
        chk("hr_update left outstanding", q_upd.size(), 0);
        chk("rr_reject left outstanding", q_rej.size(), 0);
        chk("irregular_beat left outstanding", q_irr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
